pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the five-stage core.
- Merges stall requests from ID/EX/MEM into the six-bit stall vector consumed by the PC register and the stage registers (bit0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB).
- Sequences exception/ERET redirects as a freeze-then-flush pair.
- Provides a post-reset hold and a stall-cycle performance counter.

Parameters:
- RESET_HOLD, 2: cycles after reset release during which the whole pipe is frozen (range 1..15).
- EXC_VECTOR, 32'h00000020: redirect target for any exception other than ERET.
- ERET_CODE, 5'h0e: excp_code value meaning "return from exception"; redirects to the latched EPC.
- WDT_LIMIT, 1024: consecutive stalled cycles that trip the watchdog (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- stallreq_id  in  1  ID stage requests stall (load-use etc.)
- stallreq_ex  in  1  EX stage requests stall (multi-cycle mult/div)
- stallreq_mem  in  1  MEM stage requests stall (data bus wait)
- excp_valid  in  1  MEM stage reports exception or ERET this cycle
- excp_code  in  5  cause code accompanying excp_valid
- epc_i  in  32  EPC value from CP0, sampled with excp_valid
- stall  out  6  per-stage hold vector, 1 = hold
- flush  out  1  kill all stage registers this cycle
- new_pc  out  32  redirect target, valid while flush=1
- stall_cycles  out  32  count of cycles with stall[0]=1 in RUN, saturating
- wdt_err  out  1  sticky stall-watchdog error

Behaviour:
- FSM states: HOLD, RUN, FREEZE, FLUSH. The state register, hold counter, new_pc, flush and stall_cycles are all registered. stall is combinational from state and requests.
- Reset (rst=1 at posedge) applies the following:
  - state=HOLD, hold counter=0;
  - flush=0, new_pc=0, stall_cycles=0, wdt_err=0.
  - The reset applies mid-operation from any state, discarding a pending redirect.
- HOLD:
  - stall=6'b111111.
  - The counter increments each cycle.
  - When counter==RESET_HOLD-1, next state is RUN. HOLD lasts exactly RESET_HOLD cycles.
  - excp_valid and stall requests are ignored.
- RUN, stall encoding with priority MEM > EX > ID:
  - stallreq_mem gives 6'b011111.
  - else stallreq_ex gives 6'b001111.
  - else stallreq_id gives 6'b000111.
  - else 6'b000000.
- RUN with excp_valid=1:
  - Takes priority over all stall requests. stall=6'b111111 in that same cycle.
  - new_pc is loaded: epc_i if excp_code==ERET_CODE, else EXC_VECTOR.
  - Next state is FREEZE.
- FREEZE:
  - stall=6'b111111, flush=0.
  - Exists so MEM cannot commit before the kill.
  - Next state is FLUSH, and flush is registered to 1 for the next cycle.
- FLUSH:
  - flush=1 for exactly one cycle, stall=6'b000000, new_pc stable. The PC loads new_pc.
  - Next state is RUN and flush returns to 0.
- excp_valid during FREEZE or FLUSH is ignored (the faulting stream is being killed). Stall requests during these states are ignored.
- Redirect latency: excp_valid in cycle N gives flush=1 in cycle N+2; the first redirected fetch is in cycle N+3.
- new_pc holds its last value outside FLUSH and changes only on redirect capture.
- stall_cycles:
  - Increments in RUN when stall[0]=1 and excp_valid=0.
  - Saturates at 32'hFFFFFFFF with no wrap.
  - HOLD, FREEZE and FLUSH cycles are not counted.

Optional Feature:
- Macro PIPE_CTRL_STALL_WDT_EN.
- Defined:
  - A 16-bit consecutive-stall counter increments each RUN cycle with stall[0]=1.
  - The counter clears on any RUN cycle with stall[0]=0, and on FLUSH.
  - On reaching WDT_LIMIT, wdt_err is set to 1 and remains set until rst. The counter saturates.
  - wdt_err does not alter stall or flush.
- Undefined: wdt_err is tied to 0 and no counter logic is built.

Test Plan:
- Reset release with RESET_HOLD=2, no requests: stall=6'b111111 for 2 cycles then 6'b000000; flush=0, new_pc=0, stall_cycles=0.
- RUN, stallreq_id=1 and stallreq_ex=1 for 3 cycles: stall=6'b001111 for those cycles; stall_cycles=3. Then stallreq_mem alone for 1 cycle: stall=6'b011111, stall_cycles=4.
- RUN, excp_valid=1, excp_code=5'h08, stallreq_mem=1 in cycle N:
  - stall=6'b111111 at N and N+1;
  - flush=1 with new_pc=32'h00000020 at N+2 only, stall=0;
  - back in RUN at N+3.
- excp_valid=1, excp_code=5'h0e, epc_i=32'h00400104 at N; a second excp_valid at N+1 with epc_i=32'hDEADBEEF: flush at N+2 with new_pc=32'h00400104, and the second event is ignored.
- rst asserted in the FREEZE cycle: flush never asserts; outputs return to reset values next cycle; HOLD is repeated.
- With PIPE_CTRL_STALL_WDT_EN and WDT_LIMIT=8, stallreq_ex held 8 cycles: wdt_err rises after the 8th stalled cycle and stays 1 after the request drops. With the macro undefined, the same stimulus leaves wdt_err=0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall merge, freeze/flush redirect sequencing, reset hold, stall counter.
// Optional stall watchdog built when PIPE_CTRL_STALL_WDT_EN is defined.
module pipe_ctrl #(
   parameter int          RESET_HOLD = 2,
   parameter logic [31:0] EXC_VECTOR = 32'h00000020,
   parameter logic [4:0]  ERET_CODE  = 5'h0e,
   parameter int          WDT_LIMIT  = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic        excp_valid,
   input  logic [4:0]  excp_code,
   input  logic [31:0] epc_i,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic [31:0] stall_cycles,
   output logic        wdt_err
);

   typedef enum logic [1:0] {
      HOLD   = 2'd0,
      RUN    = 2'd1,
      FREEZE = 2'd2,
      FLUSH  = 2'd3
   } state_t;

   localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD - 1);

   if (RESET_HOLD < 1 || RESET_HOLD > 15 ||
       WDT_LIMIT < 1 || WDT_LIMIT > 65535) begin : g_bad_param
      $error("pipe_ctrl: RESET_HOLD or WDT_LIMIT out of range");
   end

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  hold_cnt;
   logic        capture;
   logic        count_en;

   // Next state and combinational stall vector
   always_comb begin
      state_nxt = state;
      stall     = 6'b000000;
      capture   = 1'b0;
      count_en  = 1'b0;
      case (state)
         HOLD: begin
            stall = 6'b111111;
            if (hold_cnt == HOLD_LAST)
               state_nxt = RUN;
         end
         RUN: begin
            if (excp_valid) begin
               stall     = 6'b111111;
               capture   = 1'b1;
               state_nxt = FREEZE;
            end else begin
               if (stallreq_mem)
                  stall = 6'b011111;
               else if (stallreq_ex)
                  stall = 6'b001111;
               else if (stallreq_id)
                  stall = 6'b000111;
               count_en = stall[0];
            end
         end
         FREEZE: begin
            stall     = 6'b111111;
            state_nxt = FLUSH;
         end
         FLUSH: begin
            state_nxt = RUN;
         end
         default: begin
            state_nxt = HOLD;
         end
      endcase
   end

   // State, hold counter and one-shot flush registered after FREEZE
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= HOLD;
         hold_cnt <= 4'd0;
         flush    <= 1'b0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= (state == HOLD) ? hold_cnt + 4'd1 : 4'd0;
         flush    <= (state == FREEZE);
      end
   end

   // Redirect target captured only when the exception is accepted
   always_ff @(posedge clk) begin
      if (rst)
         new_pc <= 32'd0;
      else if (capture)
         new_pc <= (excp_code == ERET_CODE) ? epc_i : EXC_VECTOR;
   end

   // Saturating count of stalled RUN cycles
   always_ff @(posedge clk) begin
      if (rst)
         stall_cycles <= 32'd0;
      else if (count_en && stall_cycles != 32'hFFFFFFFF)
         stall_cycles <= stall_cycles + 32'd1;
   end

`ifdef PIPE_CTRL_STALL_WDT_EN
   localparam logic [15:0] WDT_MAX = 16'(WDT_LIMIT);

   logic [15:0] wdt_cnt;
   logic [15:0] wdt_nxt;

   // Consecutive-stall run length, cleared by a free cycle or a flush
   always_comb begin
      wdt_nxt = wdt_cnt;
      if (state == FLUSH)
         wdt_nxt = 16'd0;
      else if (state == RUN) begin
         if (!stall[0])
            wdt_nxt = 16'd0;
         else if (wdt_cnt != WDT_MAX)
            wdt_nxt = wdt_cnt + 16'd1;
      end
   end

   // Watchdog counter and sticky error flag
   always_ff @(posedge clk) begin
      if (rst) begin
         wdt_cnt <= 16'd0;
         wdt_err <= 1'b0;
      end else begin
         wdt_cnt <= wdt_nxt;
         if (wdt_nxt == WDT_MAX)
            wdt_err <= 1'b1;
      end
   end
`else
   assign wdt_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vectors, expected values queued per cycle,
// monitor compares at the falling edge.
module tb_pipe_ctrl;

   logic        clk;
   logic        rst;
   logic        stallreq_id;
   logic        stallreq_ex;
   logic        stallreq_mem;
   logic        excp_valid;
   logic [4:0]  excp_code;
   logic [31:0] epc_i;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic [31:0] stall_cycles;
   logic        wdt_err;

`ifdef PIPE_CTRL_STALL_WDT_EN
   localparam logic WDT_ON = 1'b1;
`else
   localparam logic WDT_ON = 1'b0;
`endif

   typedef struct {
      int          id;
      logic [5:0]  st;
      logic        fl;
      logic [31:0] pc;
      logic [31:0] sc;
      logic        wd;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   vec_id = 0;

   pipe_ctrl #(
      .RESET_HOLD (2),
      .EXC_VECTOR (32'h00000020),
      .ERET_CODE  (5'h0e),
      .WDT_LIMIT  (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stallreq_id  (stallreq_id),
      .stallreq_ex  (stallreq_ex),
      .stallreq_mem (stallreq_mem),
      .excp_valid   (excp_valid),
      .excp_code    (excp_code),
      .epc_i        (epc_i),
      .stall        (stall),
      .flush        (flush),
      .new_pc       (new_pc),
      .stall_cycles (stall_cycles),
      .wdt_err      (wdt_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step(
      input logic        r,
      input logic        id,
      input logic        ex,
      input logic        mem,
      input logic        ev,
      input logic [4:0]  code,
      input logic [31:0] epc,
      input logic [5:0]  xs,
      input logic        xf,
      input logic [31:0] xp,
      input logic [31:0] xc,
      input logic        xw
   );
      exp_t e;
      @(posedge clk);
      #1;
      rst          = r;
      stallreq_id  = id;
      stallreq_ex  = ex;
      stallreq_mem = mem;
      excp_valid   = ev;
      excp_code    = code;
      epc_i        = epc;
      e.id = vec_id;
      e.st = xs;
      e.fl = xf;
      e.pc = xp;
      e.sc = xc;
      e.wd = xw;
      exp_q.push_back(e);
      vec_id++;
   endtask

   // Monitor: one expected entry per cycle, checked mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (stall !== e.st || flush !== e.fl || new_pc !== e.pc ||
                stall_cycles !== e.sc || wdt_err !== e.wd) begin
               miscompares++;
               $display("FAIL vec%0d: got stall=%b flush=%b new_pc=%h sc=%0d wdt=%b, want stall=%b flush=%b new_pc=%h sc=%0d wdt=%b",
                        e.id, stall, flush, new_pc, stall_cycles, wdt_err,
                        e.st, e.fl, e.pc, e.sc, e.wd);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst          = 1'b1;
      stallreq_id  = 1'b0;
      stallreq_ex  = 1'b0;
      stallreq_mem = 1'b0;
      excp_valid   = 1'b0;
      excp_code    = 5'h00;
      epc_i        = 32'h0;
      @(posedge clk);
      //   rst id ex mem ev code   epc            stall      fl pc            sc wdt
      step(1, 0, 0, 0, 0, 5'h00, 32'h0,        6'b111111, 0, 32'h0,        0, 0);
      step(0, 0, 0, 0, 1, 5'h0e, 32'h00001234, 6'b111111, 0, 32'h0,        0, 0);
      step(0, 1, 0, 0, 0, 5'h00, 32'h0,        6'b111111, 0, 32'h0,        0, 0);
      step(0, 0, 0, 0, 0, 5'h00, 32'h0,        6'b000000, 0, 32'h0,        0, 0);
      step(0, 1, 1, 0, 0, 5'h00, 32'h0,        6'b001111, 0, 32'h0,        0, 0);
      step(0, 1, 1, 0, 0, 5'h00, 32'h0,        6'b001111, 0, 32'h0,        1, 0);
      step(0, 1, 1, 0, 0, 5'h00, 32'h0,        6'b001111, 0, 32'h0,        2, 0);
      step(0, 0, 0, 1, 0, 5'h00, 32'h0,        6'b011111, 0, 32'h0,        3, 0);
      step(0, 0, 0, 0, 0, 5'h00, 32'h0,        6'b000000, 0, 32'h0,        4, 0);
      step(0, 0, 0, 1, 1, 5'h08, 32'h0,        6'b111111, 0, 32'h0,        4, 0);
      step(0, 0, 1, 0, 1, 5'h0e, 32'h11111111, 6'b111111, 0, 32'h20,       4, 0);
      step(0, 0, 0, 1, 0, 5'h00, 32'h0,        6'b000000, 1, 32'h20,       4, 0);
      step(0, 1, 0, 0, 0, 5'h00, 32'h0,        6'b000111, 0, 32'h20,       4, 0);
      step(0, 0, 0, 0, 1, 5'h0e, 32'h00400104, 6'b111111, 0, 32'h20,       5, 0);
      step(0, 0, 0, 0, 1, 5'h0e, 32'hDEADBEEF, 6'b111111, 0, 32'h00400104, 5, 0);
      step(0, 0, 0, 0, 0, 5'h00, 32'h0,        6'b000000, 1, 32'h00400104, 5, 0);
      step(0, 0, 0, 0, 0, 5'h00, 32'h0,        6'b000000, 0, 32'h00400104, 5, 0);
      step(0, 0, 0, 0, 1, 5'h03, 32'h0,        6'b111111, 0, 32'h00400104, 5, 0);
      step(1, 0, 0, 0, 0, 5'h00, 32'h0,        6'b111111, 0, 32'h20,       5, 0);
      step(0, 0, 0, 0, 0, 5'h00, 32'h0,        6'b111111, 0, 32'h0,        0, 0);
      step(0, 0, 0, 0, 0, 5'h00, 32'h0,        6'b111111, 0, 32'h0,        0, 0);
      step(0, 0, 0, 0, 0, 5'h00, 32'h0,        6'b000000, 0, 32'h0,        0, 0);
      for (int k = 0; k < 8; k++)
         step(0, 0, 1, 0, 0, 5'h00, 32'h0,     6'b001111, 0, 32'h0,        32'(k), 0);
      step(0, 0, 0, 0, 0, 5'h00, 32'h0,        6'b000000, 0, 32'h0,        8, WDT_ON);
      step(0, 0, 0, 0, 0, 5'h00, 32'h0,        6'b000000, 0, 32'h0,        8, WDT_ON);
      for (int k = 0; k < 10 && exp_q.size() > 0; k++)
         @(posedge clk);
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d entries left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
